// File: rtl/fetch_sequencer.sv
// Fetch-stage redirect/stall controller: arbitrates exception, branch and jump
// redirects, holds redirects across multi-cycle freezes and inserts load-use bubbles.
module fetch_sequencer #(
  parameter logic [31:0] EXC_VEC   = 32'h0000_0004,
  parameter int unsigned FLUSH_LEN = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exc_req,
  input  logic        br_req,
  input  logic [31:0] br_target,
  input  logic        jmp_req,
  input  logic [31:0] jmp_target,
  input  logic        load_use,
  input  logic        mdu_busy,
  output logic        cond,
  output logic [31:0] condNPC,
  output logic        stall,
  output logic        flush_id,
  output logic        flush_ex,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    BUBBLE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_LEN - 1);

  state_t      state;
  logic        pend_v;
  logic [1:0]  pend_pri;
  logic [31:0] pend_tgt;
  logic [2:0]  flush_cnt;

  logic [1:0]  live_pri;
  logic [31:0] live_tgt;
  logic        win_v;
  logic [1:0]  win_pri;
  logic [31:0] win_tgt;

  // Live requests resolve first; pending only wins on strictly higher priority.
  always_comb begin
    live_pri = 2'd0;
    live_tgt = '0;
    if (exc_req) begin
      live_pri = 2'd3;
      live_tgt = EXC_VEC;
    end else if (br_req) begin
      live_pri = 2'd2;
      live_tgt = br_target;
    end else if (jmp_req) begin
      live_pri = 2'd1;
      live_tgt = jmp_target;
    end

    if (pend_v && (pend_pri > live_pri)) begin
      win_pri = pend_pri;
      win_tgt = pend_tgt;
    end else begin
      win_pri = live_pri;
      win_tgt = live_tgt;
    end
    win_v = (win_pri != 2'd0);
  end

  always_comb begin
    cond     = 1'b0;
    condNPC  = '0;
    stall    = 1'b0;
    flush_ex = 1'b0;
    flush_id = 1'b0;
    if (!rst) begin
      if (mdu_busy) begin
        stall = 1'b1;
      end else if (win_v) begin
        cond     = 1'b1;
        condNPC  = win_tgt;
        flush_ex = 1'b1;
      end else if (load_use && (state != BUBBLE)) begin
        stall    = 1'b1;
        flush_ex = 1'b1;
      end
      flush_id = !mdu_busy && (cond || (flush_cnt != 3'd0));
    end
  end

  assign state_o = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= RUN;
      pend_v    <= 1'b0;
      pend_pri  <= 2'd0;
      pend_tgt  <= '0;
      flush_cnt <= '0;
    end else if (mdu_busy) begin
      state <= WAIT;
      if (win_v) begin
        pend_v   <= 1'b1;
        pend_pri <= win_pri;
        pend_tgt <= win_tgt;
      end
    end else if (win_v) begin
      state     <= RUN;
      pend_v    <= 1'b0;
      flush_cnt <= FLUSH_RELOAD;
    end else begin
      if (flush_cnt != 3'd0)
        flush_cnt <= flush_cnt - 3'd1;
      if (load_use && (state != BUBBLE))
        state <= BUBBLE;
      else
        state <= RUN;
    end
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Pipeline-front controller that drives the fetch stage's `cond`, `condNPC` and `stall` inputs. It arbitrates PC-redirect requests from the exception unit, EX-stage branches and ID-stage jumps, and inserts load-use bubbles. It also holds redirects that arrive while a multi-cycle unit freezes the pipe, and generates the wrong-path flush window for the ID/EX latches. It sits between the hazard/branch logic and the IF stage, one instance per core.

## Interface
- `EXC_VEC`, 32'h0000_0004: exception handler address used as the target for `exc_req`.
- `FLUSH_LEN`, 2: cycles (1..7) `flush_id` stays asserted after a redirect issues, including the issue cycle.
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `exc_req`  in  1  exception redirect request, priority 3 (highest).
- `br_req`  in  1  taken-branch redirect from EX, priority 2.
- `br_target`  in  32  branch target.
- `jmp_req`  in  1  jump redirect from ID, priority 1.
- `jmp_target`  in  32  jump target.
- `load_use`  in  1  load-use hazard detected in ID.
- `mdu_busy`  in  1  multi-cycle unit busy, whole pipe must freeze.
- `cond`  out  1  redirect fetch this cycle (to IF `cond`).
- `condNPC`  out  32  redirect target (to IF `condNPC`).
- `stall`  out  1  hold PC/IR (to IF `stall`).
- `flush_id`  out  1  convert IF/ID instruction to bubble.
- `flush_ex`  out  1  insert bubble into ID/EX.
- `state_o`  out  2  FSM state, for debug: 0 RUN, 1 BUBBLE, 2 WAIT.

## Operation
- Registers: `state` (2b), `pend_v`, `pend_pri` (2b), `pend_tgt` (32b), `flush_cnt` (3b).
- Winner each cycle: the highest priority among the live requests and the pending request. On a priority tie between pending and live, the live request wins. Target: exc→`EXC_VEC`, br→`br_target`, jmp→`jmp_target`, pending→`pend_tgt`.
- Decision, evaluated in order:
  1. `mdu_busy`=1:
     - Outputs: `stall`=1, `cond`=0, `flush_ex`=0.
     - If a winner exists, it is latched into the pending registers (`pend_v`←1).
     - `flush_cnt` holds; next state WAIT.
  2. A winner exists:
     - Outputs: `cond`=1, `condNPC`=winner target, `stall`=0, `flush_ex`=1.
     - `pend_v`←0, `flush_cnt`←`FLUSH_LEN`-1; next state RUN.
     - A redirect always overrides `load_use`.
  3. `load_use`=1 and state≠BUBBLE: `stall`=1, `flush_ex`=1; next state BUBBLE.
  4. Otherwise: `stall`=0; next state RUN.
- `flush_id` = `cond` | (`flush_cnt`≠0), forced 0 while `mdu_busy`.
- `flush_cnt` decrements by 1 per non-busy cycle while non-zero. A new redirect reloads it; it never wraps below 0.
- `load_use` held high for several cycles produces exactly one bubble per RUN→BUBBLE entry. BUBBLE always returns to RUN next cycle, so a persistent `load_use` alternates stall/no-stall; upstream deasserts it once the load has advanced.
- `condNPC` = 0 whenever `cond`=0.

## Timing
- Reset (async, immediate): `state`=RUN, `pend_v`=0, `pend_pri`=0, `pend_tgt`=0, `flush_cnt`=0. All outputs 0.
- `cond`/`condNPC`/`stall`/`flush_*` are combinational from inputs plus registered state: zero-cycle latency into IF, which samples them at the next edge.
- Pending redirect issues in the first cycle with `mdu_busy`=0, with the same combinational latency.
- Reset asserted during WAIT discards the pending redirect; no `cond` after release.

## Test plan
- Reset, then idle inputs → `cond`=0, `stall`=0, `flush_id`=0, `state_o`=0 for 10 cycles.
- `br_req`=1, `br_target`=32'h0000_0040 and `jmp_req`=1, `jmp_target`=32'h0000_0080 in the same cycle → `cond`=1, `condNPC`=32'h40, `flush_id` high for exactly 2 cycles.
- `load_use` held high for 3 cycles, no redirects → `stall` pattern 1,0,1. `flush_ex` matches `stall`, and `state_o` goes 1,0,1.
- `mdu_busy` high for 4 cycles with `jmp_req`=1 (target 32'h100) in cycle 1 and `exc_req`=1 in cycle 3:
  - during busy: `stall`=1, `cond`=0;
  - first non-busy cycle: `cond`=1, `condNPC`=`EXC_VEC`.
- `load_use`=1 and `br_req`=1 (target 32'h200) together → `cond`=1, `stall`=0, `condNPC`=32'h200, no bubble.
- Pending jump latched during `mdu_busy`, then `rst` pulse mid-busy → after release and `mdu_busy`=0, `cond` stays 0.
